// File: rtl/sec_pkg.sv
// Shared types and constants for the secure command sequencer (sec_cmd_seq).
package sec_pkg;

  typedef enum logic [1:0] {
    CMD_CFG  = 2'd0,
    CMD_DATA = 2'd1,
    CMD_DBG  = 2'd2,
    CMD_RSVD = 2'd3
  } cmd_addr_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam int HOLD_CYCLES = 2;

endpackage

// File: rtl/sec_dbg_unlock.sv
// Debug unlock: key-gated enable window with a sticky lockout after repeated
// wrong keys. Only instantiated when SEC_CMD_DBG_EN is defined.
module sec_dbg_unlock #(
  parameter logic [7:0] DBG_KEY    = 8'hA5,
  parameter int         DBG_WINDOW = 16,
  parameter int         MAX_FAIL   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid_i,
  input  logic [7:0] key_i,
  output logic       key_err_o,
  output logic       dbg_en_o,
  output logic       dbg_locked_o
);

  localparam int WIN_W  = $clog2(DBG_WINDOW + 1);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  logic [WIN_W-1:0]  win_q, win_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic              locked_q, locked_d;
  logic              key_match;

  assign key_match = (key_i == DBG_KEY);
  // Rejection is computed regardless of key_valid_i; the sequencer qualifies it.
  assign key_err_o = locked_q || !key_match;

  always_comb begin
    win_d    = win_q;
    fail_d   = fail_q;
    locked_d = locked_q;
    if (win_q != '0) begin
      win_d = win_q - WIN_W'(1);
    end
    if (key_valid_i) begin
      if (!key_err_o) begin
        win_d = WIN_W'(DBG_WINDOW);
      end else if (!locked_q) begin
        // Once locked, the counter stops moving, which is what saturates it.
        fail_d = fail_q + FAIL_W'(1);
        if (fail_d == FAIL_W'(MAX_FAIL)) begin
          locked_d = 1'b1;
          win_d    = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_q    <= '0;
      fail_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      win_q    <= win_d;
      fail_q   <= fail_d;
      locked_q <= locked_d;
    end
  end

  assign dbg_en_o     = (win_q != '0);
  assign dbg_locked_o = locked_q;

endmodule

// File: rtl/sec_cmd_seq.sv
// Secure command sequencer: CFG/DATA writes with a 2-cycle hold and a sticky
// shadow lock. Define SEC_CMD_DBG_EN to include the debug unlock logic.
module sec_cmd_seq #(
  parameter logic [7:0] DBG_KEY    = 8'hA5,
  parameter int         DBG_WINDOW = 16,
  parameter int         MAX_FAIL   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_addr_i,
  input  logic [7:0] cmd_wdata_i,
  output logic       lock_o,
  output logic       re_o,
  output logic       we_o,
  output logic       dbg_en_o,
  output logic [7:0] data_o,
  output logic       err_o,
  output logic       dbg_locked_o
);

  import sec_pkg::*;

  state_e     state_q, state_d;
  logic [1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0] cfg_q, cfg_d;
  logic [7:0] data_q, data_d;
  logic       shadow_lock_q, shadow_lock_d;
  logic       err_q, err_d;
  logic       xfer;
  cmd_addr_e  cmd_addr;
  logic       dbg_key_err;

  assign xfer     = cmd_valid_i && (state_q == ST_IDLE);
  assign cmd_addr = cmd_addr_e'(cmd_addr_i);

`ifdef SEC_CMD_DBG_EN
  logic dbg_key_vld;

  assign dbg_key_vld = xfer && (cmd_addr == CMD_DBG);

  sec_dbg_unlock #(
    .DBG_KEY    (DBG_KEY),
    .DBG_WINDOW (DBG_WINDOW),
    .MAX_FAIL   (MAX_FAIL)
  ) u_dbg_unlock (
    .clk          (clk),
    .reset        (reset),
    .key_valid_i  (dbg_key_vld),
    .key_i        (cmd_wdata_i),
    .key_err_o    (dbg_key_err),
    .dbg_en_o     (dbg_en_o),
    .dbg_locked_o (dbg_locked_o)
  );
`else
  // Without the unlock logic every key is rejected, so addr 2 acts as reserved.
  assign dbg_key_err  = 1'b1;
  assign dbg_en_o     = 1'b0;
  assign dbg_locked_o = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    cfg_d         = cfg_q;
    data_d        = data_q;
    shadow_lock_d = shadow_lock_q;
    err_d         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          case (cmd_addr)
            CMD_CFG: begin
              if (shadow_lock_q) begin
                err_d = 1'b1;
              end else begin
                cfg_d         = cmd_wdata_i[2:0];
                shadow_lock_d = cmd_wdata_i[2];
                state_d       = ST_HOLD;
                hold_cnt_d    = 2'(HOLD_CYCLES - 1);
              end
            end
            CMD_DATA: begin
              data_d     = cmd_wdata_i;
              state_d    = ST_HOLD;
              hold_cnt_d = 2'(HOLD_CYCLES - 1);
            end
            CMD_DBG:  err_d = dbg_key_err;
            default:  err_d = 1'b1;
          endcase
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == 2'd0) begin
          state_d = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      hold_cnt_q    <= 2'd0;
      cfg_q         <= 3'd0;
      data_q        <= 8'd0;
      shadow_lock_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      cfg_q         <= cfg_d;
      data_q        <= data_d;
      shadow_lock_q <= shadow_lock_d;
      err_q         <= err_d;
    end
  end

  assign cmd_ready_o          = (state_q == ST_IDLE);
  assign {lock_o, re_o, we_o} = cfg_q;
  assign data_o               = data_q;
  assign err_o                = err_q;

endmodule

// File: doc/sec_cmd_seq.md
SEC_CMD_SEQ -- requirements
Module: sec_cmd_seq

Interface
REQ-001 SHALL have parameter DBG_KEY, default 8'hA5, the debug unlock key.
REQ-002 SHALL have parameter DBG_WINDOW, default 16, the number of cycles dbg_en_o stays high after a correct key.
REQ-003 SHALL have parameter MAX_FAIL, default 3, the number of wrong keys that causes permanent debug lockout.
REQ-004 SHALL have ports: clk  in  1  single clock, all logic posedge.
REQ-005 SHALL have: reset  in  1  synchronous, active-high.
REQ-006 SHALL have: cmd_valid_i  in  1  command present.
REQ-007 SHALL have: cmd_ready_o  out  1  command accepted this cycle when high with valid.
REQ-008 SHALL have: cmd_addr_i  in  2  0=CFG, 1=DATA, 2=DBG key, 3=reserved.
REQ-009 SHALL have: cmd_wdata_i  in  8  payload.
REQ-010 SHALL have: lock_o, re_o, we_o  out  1 each  cfg lines to the secure register.
REQ-011 SHALL have: dbg_en_o  out  1  debug write override.
REQ-012 SHALL have: data_o  out  8  write data to the secure register.
REQ-013 SHALL have: err_o  out  1  one-cycle pulse on a rejected command.
REQ-014 SHALL have: dbg_locked_o  out  1  debug permanently locked out.

Function
REQ-015 SHALL implement FSM IDLE, HOLD; cmd_ready_o = (state==IDLE); a transfer occurs on cmd_valid_i && cmd_ready_o.
REQ-016 CFG transfer: {lock_o,re_o,we_o} <= wdata[2:0] next cycle; FSM -> HOLD.
REQ-017 Once a CFG transfer with wdata[2]=1 is accepted, a shadow lock SHALL be set, sticky until reset; later CFG transfers SHALL be accepted, discarded, and pulse err_o.
REQ-018 DATA transfer: data_o <= wdata next cycle; FSM -> HOLD.
REQ-019 HOLD SHALL last exactly 2 cycles (2-bit counter), then return to IDLE; outputs are held stable throughout.
REQ-020 DBG transfer with wdata==DBG_KEY and not locked out: dbg_en_o high next cycle for exactly DBG_WINDOW cycles; a correct key during an active window SHALL reload the window count.
REQ-021 A DBG transfer with the wrong key SHALL increment the fail counter (saturating at MAX_FAIL), pulse err_o, and leave dbg_en_o unchanged.
REQ-022 When the fail count reaches MAX_FAIL, dbg_locked_o SHALL be set; dbg_en_o SHALL drop on the next cycle; all later DBG transfers pulse err_o.
REQ-023 DBG transfers and reserved (addr 3) transfers SHALL NOT enter HOLD; addr 3 pulses err_o only.
REQ-024 err_o SHALL be high for exactly the cycle after the rejected transfer.
REQ-025 cmd_valid_i without ready SHALL have no effect; the payload may change freely while not accepted.

Reset
REQ-026 With reset high at a clock edge, state=IDLE, and all outputs, the shadow lock, the fail counter, the window counter, and dbg_locked_o SHALL be 0, overriding any operation in flight, including HOLD and an active window.
REQ-027 cmd_ready_o SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-028 Macro SEC_CMD_DBG_EN defined: debug unlock logic (REQ-020..022) SHALL be present.
REQ-029 Macro SEC_CMD_DBG_EN undefined: dbg_en_o and dbg_locked_o SHALL be tied 0, addr 2 SHALL behave as reserved, and no window or fail counters SHALL exist.

Structure
REQ-030 Shared package sec_pkg SHALL hold the cmd address enum (CMD_CFG, CMD_DATA, CMD_DBG, CMD_RSVD), the FSM state enum, and the HOLD_CYCLES=2 constant.
REQ-031 The debug window/fail logic SHALL be one sub-module, sec_dbg_unlock, instantiated only under SEC_CMD_DBG_EN.

Verification
REQ-032 CFG wdata=8'h03, then DATA wdata=8'h5A -> re_o=we_o=1 one cycle after the first accept; data_o=8'h5A; cmd_ready_o low for 2 cycles after each accept.
REQ-033 CFG wdata=8'h07, then CFG wdata=8'h00 -> lock_o stays 1 and err_o pulses once.
REQ-034 DBG wdata=8'hA5 -> dbg_en_o high for exactly 16 cycles; a second correct key at cycle 10 -> high until cycle 26.
REQ-035 Three DBG writes of 8'h00, then 8'hA5 -> three err_o pulses, dbg_locked_o=1, a fourth err_o pulse, and dbg_en_o never asserted.
REQ-036 Reset asserted during HOLD and during an active window -> outputs 0 next cycle; cmd_ready_o=1 the cycle after release.
REQ-037 Build without SEC_CMD_DBG_EN, DBG wdata=8'hA5 -> err_o pulse and dbg_en_o=0.
